instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline; sits directly upstream of Instruction_Decode.
- Holds the PC and a word-addressed instruction memory with a load port for benches.
- Computes the next PC: PC+4 or a branch/jump redirect.
- Registers Instruction, PCPlus4 and Valid into the IF/ID pipeline register consumed by decode; honours hazard stall and flush.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words; power of two.
- ADDR_W, 8, log2(DEPTH); word-index width.
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- Clock  input  1  pipeline clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard-unit stall; hold PC and IF/ID.
- Flush  input  1  insert a bubble into IF/ID.
- PCSel  input  1  redirect request from the branch-resolve stage.
- BranchTarget  input  32  redirect byte address.
- IMemWE  input  1  instruction-memory write enable (load port).
- IMemAddr  input  32  load byte address; bits [ADDR_W+1:2] are used.
- IMemData  input  32  load word.
- PC  output  32  current fetch PC.
- Instruction  output  32  IF/ID instruction to decode.
- PCPlus4  output  32  IF/ID PC+4 of the registered instruction.
- Valid  output  1  IF/ID entry holds a real instruction.
- InstrCount  output  32  number of instructions delivered to IF/ID.

Behaviour:
- Reset (sync, highest priority):
  - PC <= RESET_PC; Instruction <= 0 (NOP); PCPlus4 <= 0; Valid <= 0; InstrCount <= 0.
  - Memory contents are not cleared.
  - Reset mid-run discards the in-flight entry; the first fetch after release is at RESET_PC.
- Instruction memory:
  - Combinational read of mem[PC[ADDR_W+1:2]].
  - Synchronous write when IMemWE=1: mem[IMemAddr[ADDR_W+1:2]] <= IMemData.
  - Write and fetch to the same index in one cycle: IF/ID captures the old word; the new word is visible next cycle.
- Index wrap: PC bits above ADDR_W+1 are ignored for indexing. PC itself keeps full 32-bit value and wraps modulo 2^32.
- Next-PC priority per edge (Reset > PCSel > Stall > normal):
  - PCSel=1: PC <= {BranchTarget[31:2],2'b00}. IF/ID <= bubble (Instruction=0, PCPlus4=0, Valid=0). This applies regardless of Stall or Flush.
  - else Stall=1: PC and all IF/ID outputs hold. Flush is ignored while stalled. InstrCount holds.
  - else Flush=1: PC <= PC+4; IF/ID <= bubble.
  - else normal: PC <= PC+4; Instruction <= mem[index]; PCPlus4 <= PC+4; Valid <= 1; InstrCount <= InstrCount+1 (wraps at 2^32).
- Latency:
  - Instruction at PC appears on IF/ID outputs one edge after PC presents it.
  - A redirect costs exactly one bubble cycle.
- Low two bits of PC are always 0.

Test Plan:
- Reset → PC=0, Instruction=0, Valid=0, InstrCount=0.
- In-order fetch: after reset, load mem[0]=32'h01098020, mem[1]=32'h2151001A, mem[2]=32'h02119022, then release Reset.
  - Edge 1 → Instruction=32'h01098020, PCPlus4=4, Valid=1, PC=4.
  - Edge 2 → 32'h2151001A, PCPlus4=8.
  - Edge 3 → 32'h02119022, PCPlus4=12, InstrCount=3.
- Stall: assert Stall for 2 cycles at PC=8 → PC stays 8, Instruction/PCPlus4/InstrCount unchanged. Deassert → 32'h02119022 delivered.
- Redirect beats stall: PCSel=1, Stall=1, BranchTarget=32'h00000043 → next edge PC=32'h40, Valid=0, Instruction=0. Following edge Instruction=mem[16], PCPlus4=32'h44.
- Flush: Flush=1 for one cycle at PC=4 → Valid=0, Instruction=0, PC=8, InstrCount unchanged. Next edge fetches mem[2].
- Wrap and reset: DEPTH=64, PC reaches 32'hFC → next edge PC=32'h100, which fetches mem[0]. Reset asserted mid-run → next edge PC=0, Valid=0, InstrCount=0.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC register, word-addressed instruction memory with a load port,
// and the IF/ID pipeline register feeding decode.
module instruction_fetch_stage #(
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        PCSel,
    input  logic [31:0] BranchTarget,
    input  logic        IMemWE,
    input  logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        Valid,
    output logic [31:0] InstrCount
);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] fetch_index;
    logic [ADDR_W-1:0] load_index;
    logic [31:0]       fetch_word;
    logic [31:0]       pc_plus4;
    logic [31:0]       redirect_pc;
    logic              unused_bits;

    assign fetch_index = PC[ADDR_W+1:2];
    assign load_index  = IMemAddr[ADDR_W+1:2];
    assign fetch_word  = mem[fetch_index];
    assign pc_plus4    = PC + 32'd4;
    assign redirect_pc = {BranchTarget[31:2], 2'b00};

    // Bits outside the word index never affect the memory.
    assign unused_bits = ^{IMemAddr[31:ADDR_W+2], IMemAddr[1:0], BranchTarget[1:0]};

    // Memory is never cleared; a same-cycle fetch of the written index sees the old word.
    always_ff @(posedge Clock) begin
        if (IMemWE) begin
            mem[load_index] <= IMemData;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            PC          <= {RESET_PC[31:2], 2'b00};
            Instruction <= 32'h0;
            PCPlus4     <= 32'h0;
            Valid       <= 1'b0;
            InstrCount  <= 32'h0;
        end else if (PCSel) begin
            PC          <= redirect_pc;
            Instruction <= 32'h0;
            PCPlus4     <= 32'h0;
            Valid       <= 1'b0;
        end else if (Stall) begin
            PC          <= PC;
        end else if (Flush) begin
            PC          <= pc_plus4;
            Instruction <= 32'h0;
            PCPlus4     <= 32'h0;
            Valid       <= 1'b0;
        end else begin
            PC          <= pc_plus4;
            Instruction <= fetch_word;
            PCPlus4     <= pc_plus4;
            Valid       <= 1'b1;
            InstrCount  <= InstrCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: a behavioural model checked every cycle,
// plus hand-computed literal expectations along a directed sequence.
module tb_instruction_fetch_stage;

    localparam int DEPTH = 64;

    logic        Clock, Reset, Stall, Flush, PCSel, IMemWE, Valid;
    logic [31:0] BranchTarget, IMemAddr, IMemData;
    logic [31:0] PC, Instruction, PCPlus4, InstrCount;

    instruction_fetch_stage #(.DEPTH(DEPTH), .ADDR_W(6), .RESET_PC(32'h0)) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush), .PCSel(PCSel),
        .BranchTarget(BranchTarget), .IMemWE(IMemWE), .IMemAddr(IMemAddr),
        .IMemData(IMemData), .PC(PC), .Instruction(Instruction), .PCPlus4(PCPlus4),
        .Valid(Valid), .InstrCount(InstrCount)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: memory as an array, PC as a plain number, rules applied in priority order.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_instr, m_p4, m_cnt;
    logic        m_valid;

    always @(posedge Clock) begin
        logic [31:0] fetched;
        fetched = m_mem[(m_pc / 4) % DEPTH];
        if (IMemWE) m_mem[(IMemAddr / 4) % DEPTH] = IMemData;
        if (Reset) begin
            m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
        end else if (PCSel) begin
            m_pc = BranchTarget - (BranchTarget % 4);
            m_instr = 0; m_p4 = 0; m_valid = 0;
        end else if (!Stall) begin
            if (Flush) begin
                m_instr = 0; m_p4 = 0; m_valid = 0;
            end else begin
                m_instr = fetched; m_p4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
            end
            m_pc = m_pc + 4;
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("model_pc", PC, m_pc);
            chk("model_instr", Instruction, m_instr);
            chk("model_pcplus4", PCPlus4, m_p4);
            chk("model_valid", {31'b0, Valid}, {31'b0, m_valid});
            chk("model_count", InstrCount, m_cnt);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic sel, input logic [31:0] bt);
        Stall = st; Flush = fl; PCSel = sel; BranchTarget = bt;
        tick();
    endtask

    function automatic logic [31:0] word_for(input int i);
        case (i)
            0:       return 32'h01098020;
            1:       return 32'h2151001A;
            2:       return 32'h02119022;
            16:      return 32'hAC110010;
            default: return 32'h3C000000 | 32'(i);
        endcase
    endfunction

    initial begin
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; PCSel = 1'b0;
        BranchTarget = 32'h0; IMemWE = 1'b0; IMemAddr = 32'h0; IMemData = 32'h0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_pc", PC, 32'h0);
        chk("reset_instr", Instruction, 32'h0);
        chk("reset_valid", {31'b0, Valid}, 32'h0);
        chk("reset_count", InstrCount, 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            IMemWE = 1'b1; IMemAddr = 32'(i * 4); IMemData = word_for(i);
            tick();
        end
        IMemWE = 1'b0;
        chk("load_hold_pc", PC, 32'h0);

        Reset = 1'b0;
        drive(0, 0, 0, 0);
        chk("e1_instr", Instruction, 32'h01098020);
        chk("e1_p4", PCPlus4, 32'h4);
        chk("e1_valid", {31'b0, Valid}, 32'h1);
        chk("e1_pc", PC, 32'h4);
        drive(0, 0, 0, 0);
        chk("e2_instr", Instruction, 32'h2151001A);
        chk("e2_p4", PCPlus4, 32'h8);

        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("stall_pc", PC, 32'h8);
        chk("stall_instr", Instruction, 32'h2151001A);
        chk("stall_count", InstrCount, 32'd2);
        drive(0, 0, 0, 0);
        chk("e3_instr", Instruction, 32'h02119022);
        chk("e3_p4", PCPlus4, 32'hC);
        chk("e3_count", InstrCount, 32'd3);

        drive(1, 0, 1, 32'h00000043);
        chk("redir_pc", PC, 32'h40);
        chk("redir_valid", {31'b0, Valid}, 32'h0);
        chk("redir_instr", Instruction, 32'h0);
        drive(0, 0, 0, 0);
        chk("redir_fetch", Instruction, 32'hAC110010);
        chk("redir_p4", PCPlus4, 32'h44);

        drive(0, 0, 1, 32'h4);
        drive(0, 1, 0, 0);
        chk("flush_valid", {31'b0, Valid}, 32'h0);
        chk("flush_pc", PC, 32'h8);
        chk("flush_count", InstrCount, 32'd4);
        drive(0, 0, 0, 0);
        chk("post_flush_instr", Instruction, 32'h02119022);
        drive(1, 1, 0, 0);
        chk("stall_beats_flush", {31'b0, Valid}, 32'h1);

        IMemWE = 1'b1; IMemAddr = 32'hC; IMemData = 32'hDEADBEEF;
        drive(0, 0, 0, 0);
        IMemWE = 1'b0;
        chk("wr_same_old", Instruction, 32'h3C000003);
        drive(0, 0, 1, 32'hC);
        drive(0, 0, 0, 0);
        chk("wr_same_new", Instruction, 32'hDEADBEEF);

        drive(0, 0, 1, 32'hFC);
        drive(0, 0, 0, 0);
        chk("wrap_pc", PC, 32'h100);
        drive(0, 0, 0, 0);
        chk("wrap_instr", Instruction, 32'h01098020);
        chk("wrap_p4", PCPlus4, 32'h104);

        drive(0, 0, 1, 32'hFFFFFFFF);
        chk("top_pc", PC, 32'hFFFFFFFC);
        drive(0, 0, 0, 0);
        chk("pc32_wrap", PC, 32'h0);
        chk("pc32_p4", PCPlus4, 32'h0);

        Reset = 1'b1;
        drive(0, 0, 0, 0);
        chk("midrst_pc", PC, 32'h0);
        chk("midrst_valid", {31'b0, Valid}, 32'h0);
        chk("midrst_count", InstrCount, 32'h0);
        Reset = 1'b0;
        drive(0, 0, 0, 0);
        chk("after_rst_instr", Instruction, 32'h01098020);
        chk("after_rst_count", InstrCount, 32'd1);

        @(negedge Clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
